rvvi_frame_decoder: RTL and testbench

Receive-side companion to the synthesizable RVVI compressor: accepts the compressed RVVI trace frame as a header-prefixed stream of 32-bit beats (e.g. from an FPGA debug link FIFO), reassembles it, unpacks every field into a decoded retirement record and presents it on a valid/ready interface. It also checks frame-count continuity and frame length. It sits at the host/checker end of the trace link, opposite the DUT-side compressor.

---
 rtl/rvvi_frame_decoder_pkg.sv | 36 +++
 rtl/rvvi_beat_deser.sv | 54 +++++
 rtl/rvvi_frame_decoder.sv | 167 ++++++++++++++++
 tb/tb_rvvi_frame_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_frame_decoder_pkg.sv
// Shared definitions for the RVVI trace frame decoder.
// Holds the frame geometry, the bit offset of every field in the compressed
// payload (LSB of the frame first) and the header beat layout.
package rvvi_frame_decoder_pkg;

    localparam int XLEN       = 64;
    localparam int MAX_CSRS   = 5;
    localparam int CSR_SLOT_W = XLEN + 16;          // {Addr[12], 4 pad, Value[XLEN]}
    localparam int REQ_W      = 3 * XLEN + 56;      // PC, Instr, Mcycle, Minstret, flags, CSRCount
    localparam int REG_W      = 2 * XLEN + 16;      // GPR + FPR write block
    localparam int RVVI_WIDTH = REQ_W + REG_W + MAX_CSRS * CSR_SLOT_W;
    localparam int EXP_BEATS  = (RVVI_WIDTH + 31) / 32;
    localparam int CSRCNT_W   = $clog2(MAX_CSRS + 1);

    localparam int OFF_PC       = 0;
    localparam int OFF_INSTR    = XLEN;
    localparam int OFF_MCYCLE   = XLEN + 32;
    localparam int OFF_MINSTRET = XLEN + 96;
    localparam int OFF_TRAP     = XLEN + 160;
    localparam int OFF_PRIV     = XLEN + 161;
    localparam int OFF_GPRWEN   = XLEN + 163;
    localparam int OFF_FPRWEN   = XLEN + 164;
    localparam int OFF_CSRCNT   = XLEN + 168;
    localparam int OFF_GPRADDR  = REQ_W;
    localparam int OFF_GPRVAL   = REQ_W + 8;
    localparam int OFF_FPRADDR  = REQ_W + 8 + XLEN;
    localparam int OFF_FPRVAL   = REQ_W + 16 + XLEN;
    localparam int OFF_CSR      = REQ_W + REG_W;
    localparam int CSR_VAL_OFS  = 16;

    typedef struct packed {
        logic [15:0] frame_count;
        logic [15:0] beat_count;
    } rvvi_hdr_t;

endpackage

// File: rtl/rvvi_beat_deser.sv
// Beat deserializer: counts accepted beats against a target and writes each
// stored beat into the frame register at its index (beat 0 = frame LSBs).
// Beats past WIDTH are counted but not stored.
//   load_i   - a beat is accepted this cycle
//   store_i  - write the accepted beat into the frame register
//   clear_i  - restart the beat counter (header accepted)
//   target_i - number of beats in the current frame
//   done_o   - the beat being accepted is the last one
//   frame_o  - assembled frame register
module rvvi_beat_deser #(
    parameter int WIDTH = 792
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             store_i,
    input  logic             clear_i,
    input  logic [15:0]      target_i,
    input  logic [31:0]      data_i,
    output logic             done_o,
    output logic [WIDTH-1:0] frame_o
);
    localparam int BEATS = (WIDTH + 31) / 32;

    logic [15:0]         cnt_q;
    logic [WIDTH-1:0]    frame_q;
    logic [BEATS*32-1:0] frame_d;
    logic                unused_hi;

    assign done_o  = load_i && (cnt_q == target_i - 16'd1);
    assign frame_o = frame_q;

    // Bits of the last beat above WIDTH fall off here.
    always_comb begin
        frame_d            = '0;
        frame_d[WIDTH-1:0] = frame_q;
        for (int b = 0; b < BEATS; b++)
            if (load_i && store_i && cnt_q == 16'(b))
                frame_d[b*32 +: 32] = data_i;
    end
    assign unused_hi = ^frame_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            frame_q <= '0;
        end else begin
            if (clear_i)     cnt_q <= '0;
            else if (load_i) cnt_q <= done_o ? 16'd0 : cnt_q + 16'd1;
            frame_q <= frame_d[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/rvvi_frame_decoder.sv
// RVVI trace frame decoder. Reassembles a header-prefixed stream of 32-bit
// beats into a frame, unpacks it into a retirement record on a valid/ready
// port and checks frame-count continuity and frame length.
//   clk, reset_n          - clock, async active-low reset
//   InValid/InReady/InData - beat input handshake
//   DecValid/DecReady      - decoded record handshake, Dec* fields
//   SeqErr/LenErr/CsrErr   - one-cycle error pulses; DropCount saturating
// Build option: define RVVI_DECODE_CSR_EN to store and decode the CSR slots;
// otherwise CSR beats are consumed and dropped and the CSR outputs read 0.
module rvvi_frame_decoder
    import rvvi_frame_decoder_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [31:0]                InData,
    output logic                       DecValid,
    input  logic                       DecReady,
    output logic [XLEN-1:0]            DecPC,
    output logic [31:0]                DecInstr,
    output logic [63:0]                DecMcycle,
    output logic [63:0]                DecMinstret,
    output logic                       DecTrap,
    output logic [1:0]                 DecPriv,
    output logic                       DecGPRWen,
    output logic                       DecFPRWen,
    output logic [4:0]                 DecGPRAddr,
    output logic [4:0]                 DecFPRAddr,
    output logic [XLEN-1:0]            DecGPRValue,
    output logic [XLEN-1:0]            DecFPRValue,
    output logic [CSRCNT_W-1:0]        DecCSRCount,
    output logic [MAX_CSRS*12-1:0]     DecCSRAddr,
    output logic [MAX_CSRS*XLEN-1:0]   DecCSRValue,
    output logic [15:0]                DecFrameCount,
    output logic                       SeqErr,
    output logic                       LenErr,
    output logic                       CsrErr,
    output logic [31:0]                DropCount
);
    localparam logic [1:0] S_HDR  = 2'd0;
    localparam logic [1:0] S_PAY  = 2'd1;
    localparam logic [1:0] S_DISC = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

`ifdef RVVI_DECODE_CSR_EN
    localparam int STORE_W = RVVI_WIDTH;
`else
    localparam int STORE_W = OFF_CSR;
`endif

    logic [1:0]         state_q, state_d;
    rvvi_hdr_t          hdr;
    logic               hdr_fire, beat_fire, done, len_bad, seq_mis;
    logic [STORE_W-1:0] frame;
    logic [15:0]        disc_q, target, exp_q, fc_q, gap;
    logic               armed_q, seq_err_q, len_err_q;
    logic [31:0]        drop_q;
    logic [32:0]        drop_sum;
    logic               unused_frame;

    assign hdr       = rvvi_hdr_t'(InData);
    assign InReady   = (state_q != S_OUT);
    assign DecValid  = (state_q == S_OUT);
    assign hdr_fire  = InValid && (state_q == S_HDR);
    assign beat_fire = InValid && (state_q == S_PAY || state_q == S_DISC);
    assign target    = (state_q == S_PAY) ? 16'(EXP_BEATS) : disc_q;
    assign len_bad   = (hdr.beat_count != 16'(EXP_BEATS)) && (hdr.beat_count != 16'd0);
    assign seq_mis   = armed_q && (hdr.frame_count != exp_q);
    assign gap       = hdr.frame_count - exp_q;   // mod 2^16 distance
    assign drop_sum  = {1'b0, drop_q} + {17'd0, gap};

    rvvi_beat_deser #(.WIDTH(STORE_W)) u_deser (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (beat_fire),
        .store_i  (state_q == S_PAY),
        .clear_i  (hdr_fire),
        .target_i (target),
        .data_i   (InData),
        .done_o   (done),
        .frame_o  (frame)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR:  if (InValid) begin
                        if (hdr.beat_count == 16'(EXP_BEATS)) state_d = S_PAY;
                        else if (len_bad)                     state_d = S_DISC;
                    end
            S_PAY:  if (done) state_d = S_OUT;
            S_DISC: if (done) state_d = S_HDR;
            default: if (DecReady) state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_HDR;
            disc_q    <= '0;
            fc_q      <= '0;
            exp_q     <= '0;
            armed_q   <= 1'b0;
            drop_q    <= '0;
            seq_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_err_q <= hdr_fire && seq_mis;
            len_err_q <= hdr_fire && len_bad;
            if (hdr_fire) begin
                disc_q  <= hdr.beat_count;
                exp_q   <= hdr.frame_count + 16'd1;
                armed_q <= 1'b1;
                if (hdr.beat_count == 16'(EXP_BEATS)) fc_q <= hdr.frame_count;
                if (seq_mis) drop_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            end
        end
    end

    assign SeqErr        = seq_err_q;
    assign LenErr        = len_err_q;
    assign DropCount     = drop_q;
    assign DecFrameCount = fc_q;

    assign DecPC       = frame[OFF_PC       +: XLEN];
    assign DecInstr    = frame[OFF_INSTR    +: 32];
    assign DecMcycle   = frame[OFF_MCYCLE   +: 64];
    assign DecMinstret = frame[OFF_MINSTRET +: 64];
    assign DecTrap     = frame[OFF_TRAP];
    assign DecPriv     = frame[OFF_PRIV     +: 2];
    assign DecGPRWen   = frame[OFF_GPRWEN];
    assign DecFPRWen   = frame[OFF_FPRWEN];
    assign DecGPRAddr  = frame[OFF_GPRADDR  +: 5];
    assign DecGPRValue = frame[OFF_GPRVAL   +: XLEN];
    assign DecFPRAddr  = frame[OFF_FPRADDR  +: 5];
    assign DecFPRValue = frame[OFF_FPRVAL   +: XLEN];
    assign unused_frame = ^frame;   // pad bits carry nothing

`ifdef RVVI_DECODE_CSR_EN
    logic [11:0] csr_raw;
    logic        csr_err_q;

    assign csr_raw     = frame[OFF_CSRCNT +: 12];
    assign DecCSRCount = (csr_raw > 12'(MAX_CSRS)) ? CSRCNT_W'(MAX_CSRS) : csr_raw[CSRCNT_W-1:0];
    assign CsrErr      = csr_err_q;

    // CSRCount sits in an early beat, so it is already stored when the last
    // beat lands; the pulse lines up with the first DecValid cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csr_err_q <= 1'b0;
        else          csr_err_q <= (state_q == S_PAY) && done && (csr_raw > 12'(MAX_CSRS));
    end

    for (genvar i = 0; i < MAX_CSRS; i++) begin : g_csr
        assign DecCSRAddr[12*i +: 12]    = frame[OFF_CSR + i*CSR_SLOT_W +: 12];
        assign DecCSRValue[XLEN*i +: XLEN] = frame[OFF_CSR + i*CSR_SLOT_W + CSR_VAL_OFS +: XLEN];
    end
`else
    assign DecCSRCount = '0;
    assign DecCSRAddr  = '0;
    assign DecCSRValue = '0;
    assign CsrErr      = 1'b0;
`endif

endmodule

// File: tb/tb_rvvi_frame_decoder.sv
module tb_rvvi_frame_decoder;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] mc;
        logic [63:0] mi;
        logic        trap;
        logic [1:0]  priv;
        logic        gw;
        logic        fw;
        logic [4:0]  ga;
        logic [4:0]  fa;
        logic [63:0] gv;
        logic [63:0] fv;
        logic [11:0] craw;
        logic [11:0] ca0;
        logic [63:0] cv0;
    } rec_t;

    typedef struct {
        rec_t        r;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n, InValid, InReady, DecValid, DecReady;
    logic [31:0] InData;
    logic [63:0] DecPC, DecMcycle, DecMinstret, DecGPRValue, DecFPRValue;
    logic [31:0] DecInstr, DropCount;
    logic DecTrap, DecGPRWen, DecFPRWen, SeqErr, LenErr, CsrErr;
    logic [1:0]  DecPriv;
    logic [4:0]  DecGPRAddr, DecFPRAddr;
    logic [2:0]  DecCSRCount;
    logic [59:0] DecCSRAddr;
    logic [319:0] DecCSRValue;
    logic [15:0] DecFrameCount;

    int n_checks = 0;
    int n_err    = 0;
    int n_seq = 0, n_len = 0, n_csr = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    rvvi_frame_decoder dut (
        .clk(clk), .reset_n(reset_n),
        .InValid(InValid), .InReady(InReady), .InData(InData),
        .DecValid(DecValid), .DecReady(DecReady),
        .DecPC(DecPC), .DecInstr(DecInstr), .DecMcycle(DecMcycle), .DecMinstret(DecMinstret),
        .DecTrap(DecTrap), .DecPriv(DecPriv), .DecGPRWen(DecGPRWen), .DecFPRWen(DecFPRWen),
        .DecGPRAddr(DecGPRAddr), .DecFPRAddr(DecFPRAddr),
        .DecGPRValue(DecGPRValue), .DecFPRValue(DecFPRValue),
        .DecCSRCount(DecCSRCount), .DecCSRAddr(DecCSRAddr), .DecCSRValue(DecCSRValue),
        .DecFrameCount(DecFrameCount),
        .SeqErr(SeqErr), .LenErr(LenErr), .CsrErr(CsrErr), .DropCount(DropCount)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Frame image built straight from the documented layout.
    function automatic logic [799:0] mk_payload(input rec_t r);
        logic [799:0] p;
        p = '0;
        p[63:0]    = r.pc;
        p[95:64]   = r.instr;
        p[159:96]  = r.mc;
        p[223:160] = r.mi;
        p[224]     = r.trap;
        p[226:225] = r.priv;
        p[227]     = r.gw;
        p[228]     = r.fw;
        p[243:232] = r.craw;
        p[252:248] = r.ga;
        p[319:256] = r.gv;
        p[324:320] = r.fa;
        p[391:328] = r.fv;
        for (int i = 0; i < 5; i++) begin
            p[392 + 80*i +: 12] = r.ca0 + 12'(i);
            p[408 + 80*i +: 64] = r.cv0 ^ 64'(i);
        end
        p[799:792] = 8'hA5;     // beyond the frame, must be ignored
        return p;
    endfunction

    function automatic rec_t rnd_rec();
        rec_t r;
        r.pc = {$urandom, $urandom};  r.instr = $urandom;
        r.mc = {$urandom, $urandom};  r.mi = {$urandom, $urandom};
        r.trap = 1'($urandom); r.priv = 2'($urandom);
        r.gw = 1'($urandom);   r.fw = 1'($urandom);
        r.ga = 5'($urandom);   r.fa = 5'($urandom);
        r.gv = {$urandom, $urandom}; r.fv = {$urandom, $urandom};
        r.craw = 12'($urandom_range(0, 5));
        r.ca0 = 12'($urandom); r.cv0 = {$urandom, $urandom};
        return r;
    endfunction

    task automatic put_beat(input logic [31:0] d);
        int t;
        t = 0;
        InValid = 1'b1;
        InData  = d;
        while (!InReady && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 200) chk("inready_timeout", {63'd0, InReady}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [15:0] fc, input logic [15:0] bc, input logic [799:0] p);
        put_beat({fc, bc});
        for (int b = 0; b < int'(bc); b++) put_beat(p[b*32 +: 32]);
        InValid = 1'b0;
    endtask

    task automatic send_rec(input rec_t r, input logic [15:0] fc);
        exp_t e;
        e.r  = r;
        e.fc = fc;
        sb.push_back(e);
        send_frame(fc, 16'd25, mk_payload(r));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        InValid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Monitor: pulse counting and scoreboard compare on each accepted record.
    exp_t        m_e;
    logic [2:0]  m_cnt;
    logic [11:0] m_ca;
    logic [63:0] m_cv;
    always @(negedge clk) begin
        if (reset_n) begin
            if (SeqErr) n_seq++;
            if (LenErr) n_len++;
            if (CsrErr) n_csr++;
            if (DecValid && DecReady) begin
                if (sb.size() == 0) chk("unexpected_rec", {63'd0, DecValid}, 64'd0);
                else begin
                    m_e = sb.pop_front();
`ifdef RVVI_DECODE_CSR_EN
                    m_cnt = (m_e.r.craw > 12'd5) ? 3'd5 : m_e.r.craw[2:0];
                    m_ca  = m_e.r.ca0;
                    m_cv  = m_e.r.cv0;
                    chk("csr_addr4", DecCSRAddr[59:48], m_e.r.ca0 + 12'd4);
                    chk("csr_val4", DecCSRValue[319:256], m_e.r.cv0 ^ 64'd4);
`else
                    m_cnt = 3'd0;
                    m_ca  = 12'd0;
                    m_cv  = 64'd0;
`endif
                    chk("pc", DecPC, m_e.r.pc);
                    chk("instr", DecInstr, m_e.r.instr);
                    chk("mcycle", DecMcycle, m_e.r.mc);
                    chk("minstret", DecMinstret, m_e.r.mi);
                    chk("trap", DecTrap, m_e.r.trap);
                    chk("priv", DecPriv, m_e.r.priv);
                    chk("gprwen", DecGPRWen, m_e.r.gw);
                    chk("fprwen", DecFPRWen, m_e.r.fw);
                    chk("gpraddr", DecGPRAddr, m_e.r.ga);
                    chk("fpraddr", DecFPRAddr, m_e.r.fa);
                    chk("gprval", DecGPRValue, m_e.r.gv);
                    chk("fprval", DecFPRValue, m_e.r.fv);
                    chk("csrcount", DecCSRCount, m_cnt);
                    chk("csr_addr0", DecCSRAddr[11:0], m_ca);
                    chk("csr_val0", DecCSRValue[63:0], m_cv);
                    chk("framecount", DecFrameCount, m_e.fc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: run did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        rec_t r;
        int s_seq, s_len, s_csr;
        reset_n  = 1'b0;
        InValid  = 1'b0;
        InData   = '0;
        DecReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        chk("rst_inready", {63'd0, InReady}, 64'd1);
        chk("rst_decvalid", {63'd0, DecValid}, 64'd0);
        chk("rst_pc", DecPC, 64'd0);
        chk("rst_drop", DropCount, 64'd0);
        chk("rst_fc", DecFrameCount, 64'd0);
        chk("rst_seqerr", {63'd0, SeqErr}, 64'd0);

        // Basic record, DecValid right after the last beat
        r = '0;
        r.pc = 64'h8000_0000; r.instr = 32'h13; r.gw = 1'b1; r.ga = 5'd5; r.gv = 64'h1234;
        send_rec(r, 16'h0000);
        chk("t1_dv_latency", {63'd0, DecValid}, 64'd1);
        drain();
        chk("t1_seq", 64'(n_seq), 64'd0);
        chk("t1_len", 64'(n_len), 64'd0);
        chk("t1_drop", DropCount, 64'd0);

        // Sequence gap 3 -> 7
        do_reset();
        s_seq = n_seq;
        send_rec(rnd_rec(), 16'h0003);
        send_rec(rnd_rec(), 16'h0007);
        drain();
        chk("t2_seq", 64'(n_seq - s_seq), 64'd1);
        chk("t2_drop", DropCount, 64'd3);

        // Reset in the middle of a payload
        put_beat({16'h0008, 16'd25});
        for (int b = 0; b < 10; b++) put_beat($urandom);
        InValid = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("mr_decvalid", {63'd0, DecValid}, 64'd0);
        chk("mr_pc", DecPC, 64'd0);
        chk("mr_gprval", DecGPRValue, 64'd0);
        chk("mr_fc", DecFrameCount, 64'd0);
        chk("mr_drop", DropCount, 64'd0);
        chk("mr_inready", {63'd0, InReady}, 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        s_seq = n_seq;
        send_rec(rnd_rec(), 16'h0100);
        drain();
        chk("mr_seq", 64'(n_seq - s_seq), 64'd0);

        // Wrap 0xFFFF -> 0x0000 is continuous
        do_reset();
        s_seq = n_seq;
        send_rec(rnd_rec(), 16'hFFFF);
        send_rec(rnd_rec(), 16'h0000);
        send_rec(rnd_rec(), 16'h0001);
        drain();
        chk("t3_seq", 64'(n_seq - s_seq), 64'd0);
        chk("t3_drop", DropCount, 64'd0);

        // Wrong length: discarded, counted in sequence
        s_seq = n_seq; s_len = n_len;
        send_frame(16'h0002, 16'd10, mk_payload(rnd_rec()));
        send_rec(rnd_rec(), 16'h0003);
        drain();
        chk("t4_len", 64'(n_len - s_len), 64'd1);
        chk("t4_seq", 64'(n_seq - s_seq), 64'd0);

        // Empty frame: no record, no LenErr, still sequenced
        s_len = n_len;
        send_frame(16'h0004, 16'd0, '0);
        send_rec(rnd_rec(), 16'h0005);
        drain();
        chk("t4z_len", 64'(n_len - s_len), 64'd0);
        chk("t4z_seq", 64'(n_seq - s_seq), 64'd0);

        // CSR count above the slot limit
        s_csr = n_csr;
        r = rnd_rec();
        r.craw = 12'd7; r.ca0 = 12'h300; r.cv0 = 64'h8;
        send_rec(r, 16'h0006);
        drain();
`ifdef RVVI_DECODE_CSR_EN
        chk("t5_csrerr", 64'(n_csr - s_csr), 64'd1);
`else
        chk("t5_csrerr", 64'(n_csr - s_csr), 64'd0);
`endif

        // Backpressure: outputs held, input stalled
        DecReady = 1'b0;
        r = rnd_rec();
        send_rec(r, 16'h0007);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_inready", {63'd0, InReady}, 64'd0);
            chk("bp_decvalid", {63'd0, DecValid}, 64'd1);
            chk("bp_pc", DecPC, r.pc);
            chk("bp_mcycle", DecMcycle, r.mc);
        end
        DecReady = 1'b1;
        drain();

        // Back-to-back random records
        for (int k = 0; k < 4; k++) send_rec(rnd_rec(), 16'(8 + k));
        drain();
        chk("rnd_seq", 64'(n_seq - s_seq), 64'd0);
        chk("rnd_drop", DropCount, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
